// File: rtl/update_pipe_pkg.sv
// update_pipe_pkg
//   Shared constants and types for the update_pipe block.
//   - DEFAULT_WIDTH / DEFAULT_DEPTH / DEFAULT_CNT_W: parameter defaults for update_pipe.
//   - cmd_e: stage-0 command, already resolved by priority (flush > load > inv > hold).
//   - decode_cmd(): priority decode of the raw control inputs into cmd_e.
package update_pipe_pkg;

   localparam int unsigned DEFAULT_WIDTH = 8;
   localparam int unsigned DEFAULT_DEPTH = 3;
   localparam int unsigned DEFAULT_CNT_W = 4;

   typedef enum logic [1:0] {
      CMD_HOLD  = 2'd0,
      CMD_INV   = 2'd1,
      CMD_LOAD  = 2'd2,
      CMD_FLUSH = 2'd3
   } cmd_e;

   function automatic cmd_e decode_cmd(input logic flush, input logic load, input logic inv);
      if (flush) begin
         return CMD_FLUSH;
      end else if (load) begin
         return CMD_LOAD;
      end else if (inv) begin
         return CMD_INV;
      end
      return CMD_HOLD;
   endfunction

endpackage

// File: rtl/update_pipe_stage.sv
// update_pipe_stage
//   One data+valid register stage of the update_pipe delay line.
//   Ports:
//     clk       in   clock, rising edge
//     rst_n     in   asynchronous active-low reset (data -> RESET_VAL, valid -> 0)
//     flush     in   synchronous clear (data -> RESET_VAL, valid -> 0)
//     in_data   in   WIDTH  data from previous stage
//     in_valid  in   valid from previous stage
//     out_data  out  WIDTH  registered data
//     out_valid out  registered valid
module update_pipe_stage #(
   parameter int unsigned      WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b1}}
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid
);

   logic [WIDTH-1:0] data_q;
   logic             valid_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q  <= RESET_VAL;
         valid_q <= 1'b0;
      end else if (flush) begin
         data_q  <= RESET_VAL;
         valid_q <= 1'b0;
      end else begin
         data_q  <= in_data;
         valid_q <= in_valid;
      end
   end

   assign out_data  = data_q;
   assign out_valid = valid_q;

endmodule

// File: rtl/update_pipe.sv
// update_pipe
//   Stage 0 is a register updated by priority command (flush > load > inv > hold),
//   followed by DEPTH-1 plain delay stages. A load+inv collision keeps the load
//   and bumps a saturating counter.
//   Ports:
//     clk         in   clock, rising edge
//     rst_n       in   asynchronous active-low reset
//     flush       in   synchronous clear of every stage (counter untouched)
//     load        in   write in_data into stage 0
//     inv         in   invert stage 0 in place (ignored when load is high)
//     in_data     in   WIDTH  load data
//     out_data    out  WIDTH  last stage data
//     out_valid   out  last stage holds data written by a load or inv
//     collide_cnt out  CNT_W  saturating count of load+inv cycles
//     out_parity  out  XOR of out_data (only with UPDATE_PIPE_PARITY_EN)
//   Build option: define UPDATE_PIPE_PARITY_EN to add out_parity; parity is computed
//   at stage 0 and travels with the data so it always lines up with out_data.
module update_pipe
   import update_pipe_pkg::*;
#(
   parameter int unsigned      WIDTH     = DEFAULT_WIDTH,
   parameter int unsigned      DEPTH     = DEFAULT_DEPTH,
   parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b1}},
   parameter int unsigned      CNT_W     = DEFAULT_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             load,
   input  logic             inv,
   input  logic [WIDTH-1:0] in_data,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
`ifdef UPDATE_PIPE_PARITY_EN
   output logic             out_parity,
`endif
   output logic [CNT_W-1:0] collide_cnt
);

   // Stage word: data, plus the parity bit on top when enabled.
`ifdef UPDATE_PIPE_PARITY_EN
   localparam int unsigned    SW          = WIDTH + 1;
   localparam logic [SW-1:0]  STAGE_RESET = {^RESET_VAL, RESET_VAL};
`else
   localparam int unsigned    SW          = WIDTH;
   localparam logic [SW-1:0]  STAGE_RESET = RESET_VAL;
`endif

   cmd_e             cmd;
   logic [WIDTH-1:0] s0_data_q, s0_data_d;
   logic             s0_valid_q, s0_valid_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cmd        = decode_cmd(flush, load, inv);
      s0_data_d  = s0_data_q;
      s0_valid_d = 1'b0;
      cnt_d      = cnt_q;
      unique case (cmd)
         CMD_FLUSH: begin
            s0_data_d  = RESET_VAL;
            s0_valid_d = 1'b0;
         end
         CMD_LOAD: begin
            s0_data_d  = in_data;
            s0_valid_d = 1'b1;
         end
         CMD_INV: begin
            s0_data_d  = ~s0_data_q;
            s0_valid_d = 1'b1;
         end
         CMD_HOLD: begin
            s0_data_d  = s0_data_q;
            s0_valid_d = 1'b0;
         end
         default: ;
      endcase
      // CMD_LOAD already excludes flush, so flushed collisions are not counted.
      if (cmd == CMD_LOAD && inv && cnt_q != {CNT_W{1'b1}}) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s0_data_q  <= RESET_VAL;
         s0_valid_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         s0_data_q  <= s0_data_d;
         s0_valid_q <= s0_valid_d;
         cnt_q      <= cnt_d;
      end
   end

   logic [SW-1:0] chain_data  [DEPTH];
   logic          chain_valid [DEPTH];

`ifdef UPDATE_PIPE_PARITY_EN
   logic s0_par_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s0_par_q <= ^RESET_VAL;
      end else begin
         s0_par_q <= ^s0_data_d;
      end
   end

   assign chain_data[0] = {s0_par_q, s0_data_q};
`else
   assign chain_data[0] = s0_data_q;
`endif
   assign chain_valid[0] = s0_valid_q;

   for (genvar g = 1; g < DEPTH; g++) begin : g_stage
      update_pipe_stage #(
         .WIDTH    (SW),
         .RESET_VAL(STAGE_RESET)
      ) u_stage (
         .clk      (clk),
         .rst_n    (rst_n),
         .flush    (flush),
         .in_data  (chain_data[g-1]),
         .in_valid (chain_valid[g-1]),
         .out_data (chain_data[g]),
         .out_valid(chain_valid[g])
      );
   end

   assign out_data    = chain_data[DEPTH-1][WIDTH-1:0];
   assign out_valid   = chain_valid[DEPTH-1];
   assign collide_cnt = cnt_q;
`ifdef UPDATE_PIPE_PARITY_EN
   assign out_parity  = chain_data[DEPTH-1][WIDTH];
`endif

endmodule

// File: tb/tb_update_pipe.sv
// tb_update_pipe
//   Scoreboard bench for update_pipe (WIDTH=8, DEPTH=3, RESET_VAL=8'hFF, CNT_W=4).
//   Stimulus pushes the hand-computed output and the cycle it is due; a monitor on
//   the falling edge pops and compares whenever out_valid is high.
module tb_update_pipe;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned DEPTH = 3;
   localparam int unsigned CNT_W = 4;

   logic             clk     = 1'b0;
   logic             rst_n   = 1'b1;
   logic             flush   = 1'b0;
   logic             load    = 1'b0;
   logic             inv     = 1'b0;
   logic [WIDTH-1:0] in_data = '0;
   logic [WIDTH-1:0] out_data;
   logic             out_valid;
   logic [CNT_W-1:0] collide_cnt;
`ifdef UPDATE_PIPE_PARITY_EN
   logic             out_parity;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   typedef struct {
      int               due;
      logic [WIDTH-1:0] data;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   update_pipe #(
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
      .RESET_VAL(8'hFF),
      .CNT_W    (CNT_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .load       (load),
      .inv        (inv),
      .in_data    (in_data),
      .out_data   (out_data),
      .out_valid  (out_valid),
`ifdef UPDATE_PIPE_PARITY_EN
      .out_parity (out_parity),
`endif
      .collide_cnt(collide_cnt)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Drive one cycle of inputs on the falling edge; the updating edge is the next
   // rising edge, and the result reaches the output DEPTH-1 edges after that.
   task automatic drive(input logic f, input logic l, input logic i, input logic [WIDTH-1:0] d,
                        input logic exp_v, input logic [WIDTH-1:0] exp_d);
      exp_t e;
      @(negedge clk);
      flush   = f;
      load    = l;
      inv     = i;
      in_data = d;
      if (exp_v) begin
         e.due  = cyc + DEPTH;
         e.data = exp_d;
         sb.push_back(e);
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
   endtask

   // Monitor
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && out_valid) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_output: got valid data %0h, expected no output (cycle %0d)",
                     out_data, cyc);
         end else begin
            e = sb.pop_front();
            check("out_cycle", cyc, e.due);
            check("out_data", {24'h0, out_data}, {24'h0, e.data});
`ifdef UPDATE_PIPE_PARITY_EN
            check("out_parity", {31'h0, out_parity}, {31'h0, ^e.data});
`endif
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset between edges takes effect immediately.
      #1 rst_n = 1'b0;
      #1;
      check("reset_out_data", {24'h0, out_data}, 32'hFF);
      check("reset_out_valid", {31'h0, out_valid}, 32'h0);
      check("reset_collide_cnt", {28'h0, collide_cnt}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Single load, valid for exactly one cycle.
      drive(1'b0, 1'b1, 1'b0, 8'h3C, 1'b1, 8'h3C);
      idle(5);

      // Collision: load wins, counter bumps.
      drive(1'b0, 1'b1, 1'b1, 8'hA5, 1'b1, 8'hA5);
      idle(4);
      check("collide_cnt_one", {28'h0, collide_cnt}, 32'h1);

      // Flush beats a collision and is not counted.
      drive(1'b1, 1'b1, 1'b1, 8'h77, 1'b0, 8'h00);
      idle(1);
      check("collide_cnt_flush_ignored", {28'h0, collide_cnt}, 32'h1);
      idle(3);

      // Toggle sequence.
      drive(1'b0, 1'b1, 1'b0, 8'h0F, 1'b1, 8'h0F);
      drive(1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 8'hF0);
      drive(1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 8'h0F);
      drive(1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 8'hF0);
      idle(5);

      // Saturation: 1 + 20 collisions must stop at 4'hF.
      for (int k = 0; k < 20; k++) begin
         drive(1'b0, 1'b1, 1'b1, 8'(k + 16), 1'b1, 8'(k + 16));
      end
      idle(4);
      check("collide_cnt_saturated", {28'h0, collide_cnt}, 32'hF);
      drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
      idle(1);
      check("collide_cnt_after_flush", {28'h0, collide_cnt}, 32'hF);

      // Flush mid-flight discards the loaded word and the concurrent load.
      drive(1'b0, 1'b1, 1'b0, 8'h11, 1'b0, 8'h00);
      drive(1'b1, 1'b1, 1'b0, 8'h22, 1'b0, 8'h00);
      for (int k = 0; k < 4; k++) begin
         idle(1);
         check("flush_out_valid", {31'h0, out_valid}, 32'h0);
         check("flush_out_data", {24'h0, out_data}, 32'hFF);
`ifdef UPDATE_PIPE_PARITY_EN
         check("flush_out_parity", {31'h0, out_parity}, 32'h0);
`endif
      end

      // Odd-parity word.
      drive(1'b0, 1'b1, 1'b0, 8'h01, 1'b1, 8'h01);
      idle(4);

      // Reset mid-operation discards in-flight data and the counter.
      drive(1'b0, 1'b1, 1'b0, 8'h55, 1'b1, 8'h55);
      drive(1'b0, 1'b1, 1'b1, 8'h66, 1'b1, 8'h66);
      #2 rst_n = 1'b0;
      #1;
      check("midreset_out_data", {24'h0, out_data}, 32'hFF);
      check("midreset_out_valid", {31'h0, out_valid}, 32'h0);
      check("midreset_collide_cnt", {28'h0, collide_cnt}, 32'h0);
      sb.delete();
      idle(1);
      // First edge with rst_n high accepts the load.
      drive(1'b0, 1'b1, 1'b0, 8'h99, 1'b1, 8'h99);
      rst_n = 1'b1;
      idle(5);
      check("collide_cnt_after_reset", {28'h0, collide_cnt}, 32'h0);

      check("scoreboard_empty", sb.size(), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
